// File: rtl/wb_host_pkg.sv
// Shared types for the Wishbone host master.
// Holds the FSM state encoding and the default byte-select width.
package wb_host_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUS  = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam int SEL_W = 32 / 8;

endpackage

// File: rtl/wb_host_master.sv
// Wishbone classic initiator fed by a valid/ready command channel.
// Ports: wb_clk_i/wb_rst_i clock and sync reset; cmd_* command in;
// rsp_* response out; wbm_* Wishbone master bus. All outputs registered.
module wb_host_master
   import wb_host_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic                wb_clk_i,
   input  logic                wb_rst_i,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic                cmd_we,
   input  logic [ADDR_W-1:0]   cmd_adr,
   input  logic [DATA_W-1:0]   cmd_dat,
   input  logic [DATA_W/8-1:0] cmd_sel,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [DATA_W-1:0]   rsp_dat,
   output logic                rsp_err,
   output logic                wbm_cyc_o,
   output logic                wbm_stb_o,
   output logic                wbm_we_o,
   output logic [ADDR_W-1:0]   wbm_adr_o,
   output logic [DATA_W-1:0]   wbm_dat_o,
   output logic [DATA_W/8-1:0] wbm_sel_o,
   input  logic                wbm_ack_i,
   input  logic [DATA_W-1:0]   wbm_dat_i
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

   state_t              state, state_n;
   logic [CNT_W-1:0]    cnt, cnt_n;
   logic                cmd_ready_n;
   logic                rsp_valid_n;
   logic [DATA_W-1:0]   rsp_dat_n;
   logic                rsp_err_n;
   logic                cyc_n;
   logic                stb_n;
   logic                we_n;
   logic [ADDR_W-1:0]   adr_n;
   logic [DATA_W-1:0]   dat_n;
   logic [DATA_W/8-1:0] sel_n;

   always_comb begin
      state_n     = state;
      cnt_n       = cnt;
      cmd_ready_n = cmd_ready;
      rsp_valid_n = rsp_valid;
      rsp_dat_n   = rsp_dat;
      rsp_err_n   = rsp_err;
      cyc_n       = wbm_cyc_o;
      stb_n       = wbm_stb_o;
      we_n        = wbm_we_o;
      adr_n       = wbm_adr_o;
      dat_n       = wbm_dat_o;
      sel_n       = wbm_sel_o;

      unique case (state)
         IDLE: begin
            // cmd_ready comes up one cycle after reset release
            cmd_ready_n = 1'b1;
            if (cmd_valid && cmd_ready) begin
               cmd_ready_n = 1'b0;
               we_n        = cmd_we;
               adr_n       = cmd_adr;
               dat_n       = cmd_dat;
               sel_n       = cmd_sel;
               cyc_n       = 1'b1;
               stb_n       = 1'b1;
               cnt_n       = '0;
               state_n     = BUS;
            end
         end
         BUS: begin
            if (cnt != CNT_MAX)
               cnt_n = cnt + CNT_W'(1);
            // ack has priority over a coincident timeout
            if (wbm_ack_i) begin
               cyc_n       = 1'b0;
               stb_n       = 1'b0;
               rsp_dat_n   = wbm_we_o ? '0 : wbm_dat_i;
               rsp_err_n   = 1'b0;
               rsp_valid_n = 1'b1;
               state_n     = RESP;
            end else if (cnt == CNT_LAST) begin
               cyc_n       = 1'b0;
               stb_n       = 1'b0;
               rsp_dat_n   = '0;
               rsp_err_n   = 1'b1;
               rsp_valid_n = 1'b1;
               state_n     = RESP;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               rsp_valid_n = 1'b0;
               cmd_ready_n = 1'b1;
               state_n     = IDLE;
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state     <= IDLE;
         cnt       <= '0;
         cmd_ready <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_dat   <= '0;
         rsp_err   <= 1'b0;
         wbm_cyc_o <= 1'b0;
         wbm_stb_o <= 1'b0;
         wbm_we_o  <= 1'b0;
         wbm_adr_o <= '0;
         wbm_dat_o <= '0;
         wbm_sel_o <= '0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         cmd_ready <= cmd_ready_n;
         rsp_valid <= rsp_valid_n;
         rsp_dat   <= rsp_dat_n;
         rsp_err   <= rsp_err_n;
         wbm_cyc_o <= cyc_n;
         wbm_stb_o <= stb_n;
         wbm_we_o  <= we_n;
         wbm_adr_o <= adr_n;
         wbm_dat_o <= dat_n;
         wbm_sel_o <= sel_n;
      end
   end

endmodule
